// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit MSB-first transfers, CLK_DIV clk cycles per
// SCLK half-period, NUM_CS active-low selects, CPOL/CPHA chosen per transfer.
module spi_master_param #(
  parameter  int DATA_W  = 32,
  parameter  int CLK_DIV = 4,
  parameter  int NUM_CS  = 1,
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [NUM_CS-1:0] CS
);

  localparam int CNT_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
  localparam logic [CS_W:0]     CS_LIM    = NUM_CS[CS_W:0];

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic                sclk_q, sclk_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [CS_W-1:0]     cs_q, cs_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic                accept, cnt_wrap, lead_edge, last_edge, first_edge;
  logic                do_sample, do_shift;
  logic [EDGE_W-1:0]   edge_nxt;

  always_comb begin
    accept     = start && (state_q == S_IDLE || state_q == S_DONE) && ({1'b0, cs_sel} < CS_LIM);
    cnt_wrap   = (cnt_q == CNT_LAST);
    edge_nxt   = edge_q + 1'b1;
    lead_edge  = edge_nxt[0];
    last_edge  = (edge_nxt == EDGE_LAST);
    first_edge = (edge_q == '0);
    // cpha=1 holds the MSB through edge 1 so the first odd edge merely re-presents it
    do_sample  = cpha_q ? !lead_edge : lead_edge;
    do_shift   = cpha_q ? (lead_edge && !first_edge) : (!lead_edge && !last_edge);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    cs_d    = cs_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_LEAD;
          cnt_d   = '0;
          edge_d  = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          sclk_d  = cpol;
          cs_d    = cs_sel;
          tx_d    = data_in;
          rx_d    = '0;
        end
      end
      S_LEAD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_wrap) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_wrap) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_nxt;
          if (do_sample) rx_d = {rx_q[DATA_W-2:0], MISO};
          if (do_shift)  tx_d = {tx_q[DATA_W-2:0], 1'b0};
          if (last_edge) state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_wrap) begin
          cnt_d   = '0;
          state_d = S_DONE;
          dout_d  = rx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      cs_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      cs_q    <= cs_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    busy     = (state_q == S_LEAD) || (state_q == S_XFER) || (state_q == S_TRAIL);
    done     = (state_q == S_DONE);
    data_out = dout_q;
    SCLK     = busy ? sclk_q : cpol_q;
    MOSI     = busy ? tx_q[DATA_W-1] : 1'b0;
    for (int i = 0; i < NUM_CS; i++)
      CS[i] = !(busy && (cs_q == CS_W'(i)));
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench: u0 (8-bit, div 2, 4 selects) covers modes 0/3, busy/back-to-back and
// mid-transfer reset; u1 (8-bit, div 1, 3 selects) covers the out-of-range select.
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, cpol0 = 1'b0, cpha0 = 1'b0;
  logic [1:0] cs_sel0 = 2'd0;
  logic [7:0] din0 = 8'h00;
  logic       busy0, done0, MOSI0, SCLK0, MISO0;
  logic [7:0] dout0;
  logic [3:0] CS0;

  logic       start1 = 1'b0;
  logic [1:0] cs_sel1 = 2'd0;
  logic       busy1, done1, MOSI1, SCLK1;
  logic [7:0] dout1;
  logic [2:0] CS1;

  logic       loop = 1'b1;
  logic       slv_en = 1'b0;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  int         s_lead = 0;
  localparam logic [7:0] S_WORD = 8'h3C;

  int n_cmp = 0, n_err = 0;
  int lat, csl, rises, cnt;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4)) u0 (
    .clk(clk), .reset(reset), .start(start0), .cpol(cpol0), .cpha(cpha0),
    .cs_sel(cs_sel0), .data_in(din0), .busy(busy0), .done(done0), .data_out(dout0),
    .MISO(MISO0), .MOSI(MOSI0), .SCLK(SCLK0), .CS(CS0));

  spi_master_param #(.DATA_W(8), .CLK_DIV(1), .NUM_CS(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .cpol(1'b0), .cpha(1'b0),
    .cs_sel(cs_sel1), .data_in(8'hFF), .busy(busy1), .done(done1), .data_out(dout1),
    .MISO(1'b0), .MOSI(MOSI1), .SCLK(SCLK1), .CS(CS1));

  // Slave for the mode-3 transfer: loads on the first leading edge, shifts on later ones
  assign MISO0 = loop ? MOSI0 : s_tx[7];
  always @(negedge SCLK0) if (slv_en) begin
    s_tx   <= (s_lead == 0) ? S_WORD : {s_tx[6:0], 1'b0};
    s_lead <= s_lead + 1;
  end
  always @(posedge SCLK0) if (slv_en) s_rx <= {s_rx[6:0], MOSI0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called in the first cycle after accept; lat = cycle index of done (0 on timeout)
  task automatic wait_done(output int l, output int c, output int r);
    logic prev;
    l = 0; c = 0; r = 0; prev = SCLK0;
    for (int n = 1; n <= 200; n++) begin
      if (CS0[0] == 1'b0) c++;
      if (SCLK0 && !prev) r++;
      prev = SCLK0;
      if (done0) begin l = n; break; end
      tick();
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(busy0), 64'h0);
    chk("rst_done", 64'(done0), 64'h0);
    chk("rst_dout", 64'(dout0), 64'h0);
    chk("rst_mosi", 64'(MOSI0), 64'h0);
    chk("rst_sclk", 64'(SCLK0), 64'h0);
    chk("rst_cs",   64'(CS0),   64'hF);
    chk("rst_cs1",  64'(CS1),   64'h7);
    reset = 1'b1;
    tick();

    // Mode 0 loopback
    din0 = 8'hA5; cs_sel0 = 2'd0; start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("m0_busy", 64'(busy0), 64'h1);
    chk("m0_cs",   64'(CS0),   64'hE);
    wait_done(lat, csl, rises);
    chk("m0_lat",   64'(lat),   64'd37);
    chk("m0_cslow", 64'(csl),   64'd36);
    chk("m0_rises", 64'(rises), 64'd8);
    chk("m0_dout",  64'(dout0), 64'hA5);
    chk("m0_donebusy", 64'(busy0), 64'h0);
    tick();
    chk("m0_idle_mosi", 64'(MOSI0), 64'h0);
    chk("m0_idle_cs",   64'(CS0),   64'hF);

    // Mode 3 against slave model
    cpol0 = 1'b1; cpha0 = 1'b1; loop = 1'b0; din0 = 8'hC3; start0 = 1'b1;
    tick(); start0 = 1'b0; slv_en = 1'b1;
    chk("m3_sclk_lead", 64'(SCLK0), 64'h1);
    wait_done(lat, csl, rises);
    slv_en = 1'b0;
    chk("m3_lat",  64'(lat),   64'd37);
    chk("m3_dout", 64'(dout0), 64'h3C);
    chk("m3_srx",  64'(s_rx),  64'hC3);
    tick();
    chk("m3_idle_sclk", 64'(SCLK0), 64'h1);
    cpol0 = 1'b0; cpha0 = 1'b0;
    tick(); tick();
    chk("cpol_wait_accept", 64'(SCLK0), 64'h1);

    // Select 2, then a start during busy with other data
    loop = 1'b1; din0 = 8'h96; cs_sel0 = 2'd2; start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("cs2_cs",   64'(CS0),   64'hB);
    chk("cs2_sclk", 64'(SCLK0), 64'h0);
    repeat (4) tick();
    din0 = 8'h5A; cs_sel0 = 2'd0; start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("bsy_busy", 64'(busy0), 64'h1);
    chk("bsy_cs",   64'(CS0),   64'hB);
    wait_done(lat, csl, rises);
    chk("bsy_lat",  64'(lat),   64'd32);
    chk("bsy_dout", 64'(dout0), 64'h96);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done0 || busy0) cnt++;
    end
    chk("bsy_no_second", 64'(cnt), 64'd0);

    // Back-to-back with start held high
    din0 = 8'h11; cs_sel0 = 2'd0; start0 = 1'b1;
    tick(); din0 = 8'h22;
    wait_done(lat, csl, rises);
    chk("b2b_lat1",  64'(lat),   64'd37);
    chk("b2b_dout1", 64'(dout0), 64'h11);
    tick(); start0 = 1'b0;
    chk("b2b_busy2", 64'(busy0), 64'h1);
    wait_done(lat, csl, rises);
    chk("b2b_lat2",  64'(lat),   64'd37);
    chk("b2b_dout2", 64'(dout0), 64'h22);

    // Out-of-range select on the 3-select instance, then a legal one
    cs_sel1 = 2'd3; start1 = 1'b1;
    tick(); tick();
    chk("oor_busy", 64'(busy1), 64'h0);
    chk("oor_cs",   64'(CS1),   64'h7);
    cs_sel1 = 2'd2;
    tick(); start1 = 1'b0;
    chk("u1_busy", 64'(busy1), 64'h1);
    chk("u1_cs",   64'(CS1),   64'h3);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      if (done1) begin lat = n; break; end
      tick();
    end
    chk("u1_lat",  64'(lat),   64'd19);
    chk("u1_dout", 64'(dout1), 64'h0);

    // Reset just after XFER edge 5
    tick();
    din0 = 8'hA5; start0 = 1'b1;
    tick(); start0 = 1'b0;
    repeat (12) tick();
    chk("rx_pre_sclk", 64'(SCLK0), 64'h1);
    chk("rx_pre_busy", 64'(busy0), 64'h1);
    #2 reset = 1'b0;
    #1;
    chk("rx_cs",   64'(CS0),   64'hF);
    chk("rx_sclk", 64'(SCLK0), 64'h0);
    chk("rx_busy", 64'(busy0), 64'h0);
    chk("rx_done", 64'(done0), 64'h0);
    chk("rx_dout", 64'(dout0), 64'h0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done0) cnt++;
    end
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done0 || busy0) cnt++;
    end
    chk("rx_no_done", 64'(cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
